// File: rtl/vga_term_writer.sv
// Text-terminal writer: turns byte/attribute/cursor commands into character and attribute RAM writes.
// Define VGA_TERM_ROWCLEAR_EN to blank each newly entered row on every row advance.
module vga_term_writer #(
    parameter int unsigned COLS        = 40,
    parameter int unsigned ROWS        = 30,
    parameter logic [7:0]  RESET_COLOR = 8'hF0
) (
    input  logic        sys_clk,
    input  logic        n_reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_sel,
    input  logic [7:0]  in_data,
    output logic        wr_en,
    output logic [12:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [5:0]  cur_col,
    output logic [5:0]  cur_row
);

    localparam logic [5:0] LastCol = 6'(COLS - 1);
    localparam logic [5:0] LastRow = 6'(ROWS - 1);
    localparam logic [7:0] CharBs  = 8'h08;
    localparam logic [7:0] CharLf  = 8'h0A;
    localparam logic [7:0] CharFf  = 8'h0C;
    localparam logic [7:0] CharCr  = 8'h0D;
    localparam logic [7:0] CharSp  = 8'h20;

    typedef enum logic [2:0] {
        StIdle,
        StWrChar,
        StWrAttr,
        StClrCellC,
        StClrCellA
`ifdef VGA_TERM_ROWCLEAR_EN
        ,
        StClrRowC,
        StClrRowA
`endif
    } state_e;

    state_e     r_state;
    state_e     w_state_nxt;
    logic [5:0] r_col;
    logic [5:0] r_row;
    logic [7:0] r_attr;
    logic [7:0] r_char;
    logic [5:0] r_clr_col;
    logic [5:0] r_clr_row;

    logic       w_accept;
    logic       w_last_col;
    logic       w_last_row;
    logic       w_clr_last_col;
    logic       w_clr_last_row;
    logic [5:0] w_col_inc;
    logic [5:0] w_row_inc;
    logic [5:0] w_col_clamp;
    logic [5:0] w_row_clamp;

    assign w_accept       = in_valid & in_ready;
    assign w_last_col     = (r_col == LastCol);
    assign w_last_row     = (r_row == LastRow);
    assign w_clr_last_col = (r_clr_col == LastCol);
    assign w_clr_last_row = (r_clr_row == LastRow);
    assign w_col_inc      = r_col + 6'd1;
    assign w_row_inc      = w_last_row ? 6'd0 : r_row + 6'd1;
    assign w_col_clamp    = (in_data > {2'b00, LastCol}) ? LastCol : in_data[5:0];
    assign w_row_clamp    = (in_data > {2'b00, LastRow}) ? LastRow : in_data[5:0];

    assign cur_col = r_col;
    assign cur_row = r_row;

    always_ff @(posedge sys_clk) begin
        if (!n_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept && in_sel == 2'd0) begin
                    case (in_data)
                        CharFf:         w_state_nxt = StClrCellC;
`ifdef VGA_TERM_ROWCLEAR_EN
                        CharLf:         w_state_nxt = StClrRowC;
`else
                        CharLf:         w_state_nxt = StIdle;
`endif
                        CharBs, CharCr: w_state_nxt = StIdle;
                        default:        w_state_nxt = StWrChar;
                    endcase
                end
            end
            StWrChar: w_state_nxt = StWrAttr;
`ifdef VGA_TERM_ROWCLEAR_EN
            StWrAttr: w_state_nxt = w_last_col ? StClrRowC : StIdle;
`else
            StWrAttr: w_state_nxt = StIdle;
`endif
            StClrCellC: w_state_nxt = StClrCellA;
            StClrCellA: begin
                w_state_nxt = (w_clr_last_col && w_clr_last_row) ? StIdle : StClrCellC;
            end
`ifdef VGA_TERM_ROWCLEAR_EN
            StClrRowC: w_state_nxt = StClrRowA;
            StClrRowA: w_state_nxt = w_clr_last_col ? StIdle : StClrRowC;
`endif
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 13'd0;
        wr_data  = 8'd0;
        unique case (r_state)
            StIdle: in_ready = 1'b1;
            StWrChar: begin
                wr_en   = 1'b1;
                wr_addr = {1'b0, r_row, r_col};
                wr_data = r_char;
            end
            StWrAttr: begin
                wr_en   = 1'b1;
                wr_addr = {1'b1, r_row, r_col};
                wr_data = r_attr;
            end
            StClrCellC: begin
                wr_en   = 1'b1;
                wr_addr = {1'b0, r_clr_row, r_clr_col};
                wr_data = CharSp;
            end
            StClrCellA: begin
                wr_en   = 1'b1;
                wr_addr = {1'b1, r_clr_row, r_clr_col};
                wr_data = r_attr;
            end
`ifdef VGA_TERM_ROWCLEAR_EN
            StClrRowC: begin
                wr_en   = 1'b1;
                wr_addr = {1'b0, r_row, r_clr_col};
                wr_data = CharSp;
            end
            StClrRowA: begin
                wr_en   = 1'b1;
                wr_addr = {1'b1, r_row, r_clr_col};
                wr_data = r_attr;
            end
`endif
            default: ;
        endcase
    end

    // Cursor, attribute and clear-scan counters.
    always_ff @(posedge sys_clk) begin
        if (!n_reset) begin
            r_col     <= 6'd0;
            r_row     <= 6'd0;
            r_attr    <= RESET_COLOR;
            r_char    <= 8'd0;
            r_clr_col <= 6'd0;
            r_clr_row <= 6'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_clr_col <= 6'd0;
                        r_clr_row <= 6'd0;
                        unique case (in_sel)
                            2'd0: begin
                                r_char <= in_data;
                                case (in_data)
                                    CharCr: r_col <= 6'd0;
                                    CharLf: begin
                                        r_col <= 6'd0;
                                        r_row <= w_row_inc;
                                    end
                                    CharBs: begin
                                        if (r_col != 6'd0) begin
                                            r_col <= r_col - 6'd1;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            2'd1: r_attr <= in_data;
                            2'd2: r_col <= w_col_clamp;
                            2'd3: r_row <= w_row_clamp;
                            default: ;
                        endcase
                    end
                end
                StWrAttr: begin
                    r_clr_col <= 6'd0;
                    if (w_last_col) begin
                        r_col <= 6'd0;
                        r_row <= w_row_inc;
                    end else begin
                        r_col <= w_col_inc;
                    end
                end
                StClrCellA: begin
                    if (w_clr_last_col) begin
                        r_clr_col <= 6'd0;
                        if (w_clr_last_row) begin
                            r_col <= 6'd0;
                            r_row <= 6'd0;
                        end else begin
                            r_clr_row <= r_clr_row + 6'd1;
                        end
                    end else begin
                        r_clr_col <= r_clr_col + 6'd1;
                    end
                end
`ifdef VGA_TERM_ROWCLEAR_EN
                StClrRowA: r_clr_col <= r_clr_col + 6'd1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_term_writer.sv
// Randomized self-checking bench for vga_term_writer against a screen-level command model.
// Honours VGA_TERM_ROWCLEAR_EN in the model the same way as the design.
module tb_vga_term_writer;

    localparam int COLS = 40;
    localparam int ROWS = 30;

    logic        sys_clk = 1'b0;
    logic        n_reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic [5:0]  cur_col;
    logic [5:0]  cur_row;

    always #5 sys_clk = ~sys_clk;

    vga_term_writer #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .RESET_COLOR (8'hF0)
    ) dut (
        .sys_clk  (sys_clk),
        .n_reset  (n_reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cur_col  (cur_col),
        .cur_row  (cur_row)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int m_col;
    int m_row;
    int m_attr;
    int exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected write entry = address * 256 + data.
    task automatic push_wr(input int plane, input int row, input int col, input int data);
        exp_q.push_back((plane * 4096 + row * 64 + col) * 256 + data);
    endtask

    task automatic model_reset();
        m_col  = 0;
        m_row  = 0;
        m_attr = 8'hF0;
        exp_q.delete();
    endtask

    task automatic model_row_adv();
        m_row = (m_row + 1) % ROWS;
`ifdef VGA_TERM_ROWCLEAR_EN
        for (int c = 0; c < COLS; c++) begin
            push_wr(0, m_row, c, 8'h20);
            push_wr(1, m_row, c, m_attr);
        end
`endif
    endtask

    task automatic model_cmd(input int sel, input int data);
        case (sel)
            0: begin
                if (data == 8'h0C) begin
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 0; c < COLS; c++) begin
                            push_wr(0, r, c, 8'h20);
                            push_wr(1, r, c, m_attr);
                        end
                    end
                    m_col = 0;
                    m_row = 0;
                end else if (data == 8'h0D) begin
                    m_col = 0;
                end else if (data == 8'h0A) begin
                    m_col = 0;
                    model_row_adv();
                end else if (data == 8'h08) begin
                    if (m_col > 0) m_col--;
                end else begin
                    push_wr(0, m_row, m_col, data);
                    push_wr(1, m_row, m_col, m_attr);
                    m_col++;
                    if (m_col == COLS) begin
                        m_col = 0;
                        model_row_adv();
                    end
                end
            end
            1: m_attr = data;
            2: m_col = (data > COLS - 1) ? COLS - 1 : data;
            default: m_row = (data > ROWS - 1) ? ROWS - 1 : data;
        endcase
    endtask

    // Issue one command at a negedge, keep in_valid high while busy, check every cycle.
    task automatic do_cmd(input logic [1:0] sel, input logic [7:0] data);
        int guard = 0;
        int e;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge sys_clk);
            guard++;
        end
        if (guard >= 100) check_eq("ready_timeout", in_ready, 1);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        model_cmd(sel, data);
        @(negedge sys_clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("busy_wr_en", wr_en, 1);
            check_eq("busy_wr_addr", wr_addr, e / 256);
            check_eq("busy_wr_data", wr_data, e % 256);
            check_eq("busy_ready", in_ready, 0);
            @(negedge sys_clk);
        end
        check_eq("done_ready", in_ready, 1);
        check_eq("done_wr_en", wr_en, 0);
        check_eq("done_col", cur_col, m_col);
        check_eq("done_row", cur_row, m_row);
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            check_eq("idle_wr_en", wr_en, 0);
            check_eq("idle_ready", in_ready, 1);
        end
    endtask

    initial begin
        int r;
        logic [1:0] sel;
        logic [7:0] data;

        n_reset  = 1'b0;
        in_valid = 1'b0;
        in_sel   = 2'd0;
        in_data  = 8'd0;
        model_reset();
        repeat (2) @(negedge sys_clk);
        check_eq("rst_ready", in_ready, 1);
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_col", cur_col, 0);
        check_eq("rst_row", cur_row, 0);
        n_reset = 1'b1;
        idle_cycles(2);

        // First character after reset.
        do_cmd(2'd0, 8'h41);
        check_eq("first_put_col", cur_col, 1);

        // Wrap from last column with a custom attribute.
        do_cmd(2'd3, 8'd5);
        do_cmd(2'd2, 8'd39);
        do_cmd(2'd1, 8'h1C);
        do_cmd(2'd0, 8'h42);
        check_eq("wrap_col", cur_col, 0);
        check_eq("wrap_row", cur_row, 6);

        // Screen corner, LF wrap, BS at column 0, clamping.
        do_cmd(2'd3, 8'd29);
        do_cmd(2'd2, 8'd39);
        do_cmd(2'd0, 8'h58);
        check_eq("corner_col", cur_col, 0);
        check_eq("corner_row", cur_row, 0);
        do_cmd(2'd3, 8'd29);
        do_cmd(2'd0, 8'h0A);
        check_eq("lf_wrap_row", cur_row, 0);
        do_cmd(2'd0, 8'h08);
        check_eq("bs_col0", cur_col, 0);
        do_cmd(2'd2, 8'd100);
        check_eq("clamp_col", cur_col, 39);
        do_cmd(2'd3, 8'd200);
        check_eq("clamp_row", cur_row, 29);

        // Full clear screen.
        do_cmd(2'd0, 8'h0C);
        idle_cycles(3);

        // Reset in the middle of a clear.
        do_cmd(2'd1, 8'h5A);
        do_cmd(2'd3, 8'd7);
        do_cmd(2'd2, 8'd3);
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 8'h0C;
        for (int i = 0; i < 500; i++) begin
            @(negedge sys_clk);
            check_eq("mid_clr_wr_en", wr_en, 1);
            if (i == 0) begin
                check_eq("mid_clr_first_addr", wr_addr, 13'h0000);
                check_eq("mid_clr_first_data", wr_data, 8'h20);
            end
            if (i == 499) begin
                check_eq("mid_clr_500_addr", wr_addr, 13'h1189);
                check_eq("mid_clr_500_data", wr_data, 8'h5A);
            end
        end
        n_reset  = 1'b0;
        in_valid = 1'b0;
        @(negedge sys_clk);
        check_eq("abort_wr_en", wr_en, 0);
        check_eq("abort_ready", in_ready, 1);
        check_eq("abort_col", cur_col, 0);
        check_eq("abort_row", cur_row, 0);
        n_reset = 1'b1;
        model_reset();
        idle_cycles(30);
        do_cmd(2'd0, 8'h41);

        // Randomized command stream.
        for (int n = 0; n < 300; n++) begin
            sel = 2'($urandom_range(0, 3));
            data = 8'($urandom_range(0, 255));
            if (sel == 2'd0) begin
                r = $urandom_range(0, 99);
                if (r < 2)       data = 8'h0C;
                else if (r < 12) data = 8'h0A;
                else if (r < 20) data = 8'h08;
                else if (r < 25) data = 8'h0D;
                else if (data == 8'h0C) data = 8'h2A;
            end else if (sel != 2'd1 && $urandom_range(0, 3) != 0) begin
                data = 8'($urandom_range(0, 45));
            end
            do_cmd(sel, data);
            in_sel  = 2'($urandom_range(0, 3));
            in_data = 8'($urandom_range(0, 255));
            idle_cycles($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
